// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: stall unit for the MIPS ID stage.
// It combines the pipeline RAW, load-use and branch checks with a one-entry
// scoreboard for the non-pipelined long-latency (mul/div) unit.
// Optional macro HAZARD_STATS_EN enables a saturating stall counter.
// When the macro is undefined, stall_count is tied to zero.
module hazard_scoreboard #(
    parameter int REG_ADDR_W = 5,
    parameter int MAX_LAT    = 32,
    parameter int LAT_W      = 6,
    parameter int STAT_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  forward_EN,
    input  logic                  id_valid,
    input  logic                  flush,
    input  logic [REG_ADDR_W-1:0] src1_ID,
    input  logic [REG_ADDR_W-1:0] src2_ID,
    input  logic                  src2_valid_ID,
    input  logic                  branch_ID,
    input  logic [REG_ADDR_W-1:0] dest_ID,
    input  logic                  WB_EN_ID,
    input  logic                  long_ID,
    input  logic [LAT_W-1:0]      lat_ID,
    input  logic [REG_ADDR_W-1:0] dest_EXE,
    input  logic                  WB_EN_EXE,
    input  logic                  MEM_R_EN_EXE,
    input  logic [REG_ADDR_W-1:0] dest_MEM,
    input  logic                  WB_EN_MEM,
    output logic                  hazard_detected,
    output logic                  long_busy,
    output logic                  long_done,
    output logic [REG_ADDR_W-1:0] long_dest,
    output logic [STAT_W-1:0]     stall_count
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                state, state_next;
    logic [LAT_W-1:0]      cnt, cnt_next;
    logic [REG_ADDR_W-1:0] dest_q, dest_next;
    logic [LAT_W-1:0]      eff_lat;
    logic                  match_exe, match_mem, match_long;
    logic                  raw_exe, raw_mem, pipe_hz;
    logic                  sb_raw, sb_waw, sb_struct;
    logic                  issue;

    // A source matches a destination only if it is read and is not $zero
    function automatic logic src_match(
        input logic [REG_ADDR_W-1:0] d,
        input logic [REG_ADDR_W-1:0] s1,
        input logic [REG_ADDR_W-1:0] s2,
        input logic                  s2_valid
    );
        return (d != '0) && ((s1 == d) || (s2_valid && (s2 == d)));
    endfunction

    assign match_exe  = src_match(dest_EXE, src1_ID, src2_ID, src2_valid_ID);
    assign match_mem  = src_match(dest_MEM, src1_ID, src2_ID, src2_valid_ID);
    assign match_long = src_match(dest_q,   src1_ID, src2_ID, src2_valid_ID);

    assign raw_exe = WB_EN_EXE && match_exe;
    assign raw_mem = WB_EN_MEM && match_mem;

    // With forwarding only branches (resolved in ID) and load-use need to stall
    always_comb begin
        if (forward_EN)
            pipe_hz = (branch_ID && (raw_exe || raw_mem)) || (MEM_R_EN_EXE && raw_exe);
        else
            pipe_hz = raw_exe || raw_mem;
    end

    assign long_busy = (state == BUSY);
    assign long_dest = dest_q;

    assign sb_raw    = long_busy && match_long;
    assign sb_waw    = long_busy && WB_EN_ID && (dest_ID == dest_q) && (dest_ID != '0);
    assign sb_struct = long_busy && long_ID;

    assign hazard_detected = id_valid && !flush && (pipe_hz || sb_raw || sb_waw || sb_struct);
    assign issue           = id_valid && !flush && !hazard_detected && long_ID;

    // Zero latency behaves as one cycle; oversized requests clamp to the unit maximum
    always_comb begin
        eff_lat = lat_ID;
        if (lat_ID == '0)
            eff_lat = LAT_W'(1);
        else if (lat_ID > LAT_W'(MAX_LAT))
            eff_lat = LAT_W'(MAX_LAT);
    end

    // Scoreboard state register; reset drops any pending long op
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            dest_q <= '0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            dest_q <= dest_next;
        end
    end

    // Scoreboard next state; cnt holds the busy cycles left after the current one
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        dest_next  = dest_q;
        long_done  = 1'b0;
        case (state)
            IDLE: begin
                if (issue) begin
                    state_next = BUSY;
                    dest_next  = dest_ID;
                    cnt_next   = eff_lat - LAT_W'(1);
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    long_done  = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt - LAT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef HAZARD_STATS_EN
    logic [STAT_W-1:0] stat_q;

    // Count stalled cycles, holding at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (rst)
            stat_q <= '0;
        else if (hazard_detected && (stat_q != '1))
            stat_q <= stat_q + STAT_W'(1);
    end

    assign stall_count = stat_q;
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: scoreboard bench for hazard_scoreboard.
// The stimulus side pushes the expected outputs of each cycle into a queue.
// A monitor pops those entries on the falling edge and compares them.
// Expected values come from a cycle-count model of the long unit.
module tb_hazard_scoreboard;

    localparam int AW      = 5;
    localparam int LW      = 6;
    localparam int SW      = 2;
    localparam int MAXL    = 32;
    localparam int STATMAX = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          forward_EN, id_valid, flush;
    logic [AW-1:0] src1_ID, src2_ID, dest_ID, dest_EXE, dest_MEM;
    logic          src2_valid_ID, branch_ID, WB_EN_ID, long_ID;
    logic [LW-1:0] lat_ID;
    logic          WB_EN_EXE, MEM_R_EN_EXE, WB_EN_MEM;
    logic          hazard_detected, long_busy, long_done;
    logic [AW-1:0] long_dest;
    logic [SW-1:0] stall_count;

    typedef struct {
        logic          hz;
        logic          busy;
        logic          done;
        logic [AW-1:0] ldest;
        logic [SW-1:0] sc;
        string         tag;
    } exp_t;

    exp_t          expq[$];
    int            total = 0;
    int            bad = 0;
    int            busy_left = 0;
    logic [AW-1:0] m_dest = '0;
    int            m_stall = 0;

    hazard_scoreboard #(
        .REG_ADDR_W(AW), .MAX_LAT(MAXL), .LAT_W(LW), .STAT_W(SW)
    ) dut (
        .clk(clk), .rst(rst), .forward_EN(forward_EN), .id_valid(id_valid),
        .flush(flush), .src1_ID(src1_ID), .src2_ID(src2_ID),
        .src2_valid_ID(src2_valid_ID), .branch_ID(branch_ID), .dest_ID(dest_ID),
        .WB_EN_ID(WB_EN_ID), .long_ID(long_ID), .lat_ID(lat_ID),
        .dest_EXE(dest_EXE), .WB_EN_EXE(WB_EN_EXE), .MEM_R_EN_EXE(MEM_R_EN_EXE),
        .dest_MEM(dest_MEM), .WB_EN_MEM(WB_EN_MEM),
        .hazard_detected(hazard_detected), .long_busy(long_busy),
        .long_done(long_done), .long_dest(long_dest), .stall_count(stall_count)
    );

    // Free-running clock
    always #5 clk = ~clk;

    function automatic logic model_match(input logic [AW-1:0] d);
        return (d != 0) && ((src1_ID == d) || (src2_valid_ID && (src2_ID == d)));
    endfunction

    // Hazard decision straight from the rules, with the long unit seen as a countdown
    function automatic logic model_hazard();
        logic re, rm, pipe, sb;
        re = WB_EN_EXE && model_match(dest_EXE);
        rm = WB_EN_MEM && model_match(dest_MEM);
        if (forward_EN)
            pipe = (branch_ID && (re || rm)) || (MEM_R_EN_EXE && re);
        else
            pipe = re || rm;
        sb = (busy_left > 0) && (model_match(m_dest)
             || (WB_EN_ID && dest_ID == m_dest && dest_ID != 0) || long_ID);
        return id_valid && !flush && (pipe || sb);
    endfunction

    task automatic clearInputs();
        rst = 1'b0; forward_EN = 1'b0; id_valid = 1'b1; flush = 1'b0;
        src1_ID = '0; src2_ID = '0; src2_valid_ID = 1'b0; branch_ID = 1'b0;
        dest_ID = '0; WB_EN_ID = 1'b0; long_ID = 1'b0; lat_ID = '0;
        dest_EXE = '0; WB_EN_EXE = 1'b0; MEM_R_EN_EXE = 1'b0;
        dest_MEM = '0; WB_EN_MEM = 1'b0;
    endtask

    // Queue this cycle's expectation, then advance the model across the clock edge
    task automatic applyStimulus(input string tag);
        exp_t e;
        logic hz;
        int   lat;
        hz      = model_hazard();
        e.hz    = hz;
        e.busy  = (busy_left > 0);
        e.done  = (busy_left == 1);
        e.ldest = m_dest;
`ifdef HAZARD_STATS_EN
        e.sc    = SW'(m_stall);
`else
        e.sc    = '0;
`endif
        e.tag   = tag;
        expq.push_back(e);
        @(posedge clk);
        if (rst) begin
            busy_left = 0;
            m_dest    = '0;
            m_stall   = 0;
        end else begin
            if (hz && m_stall < STATMAX) m_stall++;
            if (busy_left > 0) begin
                busy_left--;
            end else if (id_valid && !flush && !hz && long_ID) begin
                lat = int'(lat_ID);
                if (lat == 0) lat = 1;
                if (lat > MAXL) lat = MAXL;
                busy_left = lat;
                m_dest    = dest_ID;
            end
        end
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s got=%0h expected=%0h", name, got, want);
        end
    endtask

    // Monitor: compare DUT outputs against the oldest queued expectation
    always @(negedge clk) begin
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            checkOutput({e.tag, "/hazard"}, 32'(hazard_detected), 32'(e.hz));
            checkOutput({e.tag, "/busy"},   32'(long_busy),       32'(e.busy));
            checkOutput({e.tag, "/done"},   32'(long_done),       32'(e.done));
            checkOutput({e.tag, "/dest"},   32'(long_dest),       32'(e.ldest));
            checkOutput({e.tag, "/stats"},  32'(stall_count),     32'(e.sc));
        end
    end

    initial begin
        clearInputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        applyStimulus("reset");
        rst = 1'b0;

        // Non-forwarding RAW against EXE, and $zero exclusion
        src1_ID = 5'd3; WB_EN_EXE = 1'b1; dest_EXE = 5'd3;
        applyStimulus("raw_exe_nofwd");
        src1_ID = 5'd0; dest_EXE = 5'd0;
        applyStimulus("zero_reg");

        // Load-use through src2, then the branch path via MEM
        clearInputs();
        forward_EN = 1'b1; MEM_R_EN_EXE = 1'b1; WB_EN_EXE = 1'b1; dest_EXE = 5'd7;
        src1_ID = 5'd1; src2_ID = 5'd7; src2_valid_ID = 1'b1;
        applyStimulus("load_use_src2");
        src2_valid_ID = 1'b0;
        applyStimulus("load_use_src2_unused");
        MEM_R_EN_EXE = 1'b0; WB_EN_EXE = 1'b0; src2_valid_ID = 1'b1;
        branch_ID = 1'b1; WB_EN_MEM = 1'b1; dest_MEM = 5'd7;
        applyStimulus("branch_mem");
        src1_ID = 5'd7; dest_MEM = 5'd4; src2_ID = 5'd2;
        applyStimulus("fwd_no_branch_hit");

        // Long op dest 9 latency 4, followed by a dependent reader
        clearInputs();
        long_ID = 1'b1; dest_ID = 5'd9; WB_EN_ID = 1'b1; lat_ID = 6'd4;
        applyStimulus("issue_lat4");
        clearInputs();
        src1_ID = 5'd9;
        repeat (5) applyStimulus("raw_long");

        // WAW then structural; the second issue lands after long_done
        long_ID = 1'b1; dest_ID = 5'd9; WB_EN_ID = 1'b1; lat_ID = 6'd6; src1_ID = 5'd0;
        applyStimulus("issue_lat6");
        long_ID = 1'b0;
        repeat (2) applyStimulus("waw");
        long_ID = 1'b1; dest_ID = 5'd5; lat_ID = 6'd3;
        repeat (5) applyStimulus("struct");
        clearInputs();
        repeat (3) applyStimulus("drain");

        // Zero latency means one busy cycle; oversized latency clamps
        long_ID = 1'b1; dest_ID = 5'd2; WB_EN_ID = 1'b1; lat_ID = 6'd0;
        applyStimulus("issue_lat0");
        clearInputs();
        repeat (2) applyStimulus("lat0_busy");
        long_ID = 1'b1; dest_ID = 5'd6; lat_ID = 6'd50;
        applyStimulus("issue_clamp");
        clearInputs();
        repeat (33) applyStimulus("clamp_busy");

        // Reset two cycles into a latency-10 op
        long_ID = 1'b1; dest_ID = 5'd11; WB_EN_ID = 1'b1; lat_ID = 6'd10;
        applyStimulus("issue_lat10");
        clearInputs();
        src1_ID = 5'd11;
        repeat (2) applyStimulus("pre_reset");
        rst = 1'b1;
        applyStimulus("mid_reset");
        rst = 1'b0;
        repeat (2) applyStimulus("post_reset");

        // Hold a pipeline hazard to exercise counter saturation
        clearInputs();
        src1_ID = 5'd3; WB_EN_EXE = 1'b1; dest_EXE = 5'd3;
        repeat (7) applyStimulus("stats_hold");

        // Randomized traffic on a small register range to provoke matches
        for (int i = 0; i < 400; i++) begin
            rst           = ($urandom_range(0, 60) == 0);
            forward_EN    = 1'($urandom);
            id_valid      = ($urandom_range(0, 7) != 0);
            flush         = ($urandom_range(0, 7) == 0);
            src1_ID       = AW'($urandom_range(0, 3));
            src2_ID       = AW'($urandom_range(0, 3));
            src2_valid_ID = 1'($urandom);
            branch_ID     = ($urandom_range(0, 3) == 0);
            dest_ID       = AW'($urandom_range(0, 3));
            WB_EN_ID      = 1'($urandom);
            long_ID       = ($urandom_range(0, 3) == 0);
            lat_ID        = ($urandom_range(0, 9) == 0) ? LW'(40) : LW'($urandom_range(0, 6));
            dest_EXE      = AW'($urandom_range(0, 3));
            WB_EN_EXE     = 1'($urandom);
            MEM_R_EN_EXE  = 1'($urandom);
            dest_MEM      = AW'($urandom_range(0, 3));
            WB_EN_MEM     = 1'($urandom);
            applyStimulus("random");
        end

        clearInputs();
        @(negedge clk);
        #1;
        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("[TB] FAIL drain got=%0d expected=0", expq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
